// File: rtl/hpu_pkg.sv
// Shared HPU definitions for the unpermute path: word width, FSM state type
// and the word-level funnel used to rebuild one rotated output word.
package hpu_pkg;

   localparam int HV_WORD_W = 32;
   localparam int BIT_OFF_W = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      EMIT = 2'd2
   } unperm_state_t;

   // Upper half of {hi,lo} << r; r=0 yields hi without ever shifting by 32.
   function automatic logic [HV_WORD_W-1:0] rotl_word_sel(
      input logic [HV_WORD_W-1:0] hi,
      input logic [HV_WORD_W-1:0] lo,
      input logic [BIT_OFF_W-1:0] r
   );
      logic [2*HV_WORD_W-1:0] pair;
      pair = {hi, lo} << r;
      return pair[2*HV_WORD_W-1:HV_WORD_W];
   endfunction

endpackage

// File: rtl/hv_funnel_word.sv
// Combinational funnel: one output word from the two buffer words that
// straddle it, shifted left by the bit offset r.
module hv_funnel_word
   import hpu_pkg::*;
(
   input  logic [HV_WORD_W-1:0] hi_word,
   input  logic [HV_WORD_W-1:0] lo_word,
   input  logic [BIT_OFF_W-1:0] bit_off,
   output logic [HV_WORD_W-1:0] out_word
);

   always_comb begin
      out_word = rotl_word_sel(hi_word, lo_word, bit_off);
   end

endmodule

// File: rtl/hv_unpermute.sv
// Streaming inverse permutation: buffers one N_WORDS x 32 hypervector and
// emits it rotated left by the shift latched with its first word.
module hv_unpermute
   import hpu_pkg::*;
#(
   parameter int N_WORDS = 8,
   parameter int SHIFT_W = ($clog2(32 * N_WORDS) < 5) ? 5 : $clog2(32 * N_WORDS)
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [HV_WORD_W-1:0] s_data,
   input  logic [SHIFT_W-1:0]   s_shift,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [HV_WORD_W-1:0] m_data,
   output logic                 m_last
);

   localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);
   // N_WORDS is a power of two, so masking with N-1 gives the modulo wrap.
   localparam logic [IDX_W-1:0] IDX_MASK = LAST_IDX;

   unperm_state_t state_q, state_d;
   logic [IDX_W-1:0]     wr_cnt_q, wr_cnt_d;
   logic [IDX_W-1:0]     rd_cnt_q, rd_cnt_d;
   logic [SHIFT_W-1:0]   shift_q, shift_d;
   logic                 s_ready_q, s_ready_d;
   logic                 m_valid_q, m_valid_d;
   logic                 m_last_q, m_last_d;
   logic [HV_WORD_W-1:0] m_data_q, m_data_d;

   logic [HV_WORD_W-1:0] buf_mem [N_WORDS];

   logic                 s_hs;
   logic                 m_hs;
   logic                 load_last;
   logic [SHIFT_W-1:0]   shift_eff;
   logic [IDX_W-1:0]     word_off;
   logic [IDX_W-1:0]     next_rd;
   logic [IDX_W-1:0]     sel_word;
   logic [IDX_W-1:0]     hi_idx;
   logic [IDX_W-1:0]     lo_idx;
   logic [HV_WORD_W-1:0] hi_word;
   logic [HV_WORD_W-1:0] lo_word;
   logic [HV_WORD_W-1:0] funnel_word;

   assign s_hs      = s_valid & s_ready_q;
   assign m_hs      = m_valid_q & m_ready;
   assign load_last = s_hs && (wr_cnt_q == LAST_IDX);
   assign next_rd   = rd_cnt_q + 1'b1;

   // A single-word vector finishes on its first handshake, before shift_q is loaded.
   assign shift_eff = (state_q == LOAD && wr_cnt_q == '0) ? s_shift : shift_q;

   generate
      if (SHIFT_W > BIT_OFF_W && N_WORDS > 1) begin : g_word_off
         assign word_off = IDX_W'(shift_eff[SHIFT_W-1:BIT_OFF_W]);
      end else begin : g_no_word_off
         assign word_off = '0;
      end
   endgenerate

   assign sel_word = (state_q == EMIT) ? next_rd : '0;
   assign hi_idx   = (sel_word - word_off) & IDX_MASK;
   assign lo_idx   = (sel_word - word_off - 1'b1) & IDX_MASK;

   // Word 0 is built while the final input word is still on s_data, so bypass it.
   assign hi_word = (load_last && hi_idx == LAST_IDX) ? s_data : buf_mem[hi_idx];
   assign lo_word = (load_last && lo_idx == LAST_IDX) ? s_data : buf_mem[lo_idx];

   hv_funnel_word u_funnel (
      .hi_word  (hi_word),
      .lo_word  (lo_word),
      .bit_off  (shift_eff[BIT_OFF_W-1:0]),
      .out_word (funnel_word)
   );

   always_comb begin
      state_d   = state_q;
      wr_cnt_d  = wr_cnt_q;
      rd_cnt_d  = rd_cnt_q;
      shift_d   = shift_q;
      s_ready_d = s_ready_q;
      m_valid_d = m_valid_q;
      m_last_d  = m_last_q;
      m_data_d  = m_data_q;
      case (state_q)
         IDLE: begin
            state_d   = LOAD;
            s_ready_d = 1'b1;
         end
         LOAD: begin
            if (s_hs) begin
               if (wr_cnt_q == '0) begin
                  shift_d = s_shift;
               end
               if (load_last) begin
                  wr_cnt_d  = '0;
                  state_d   = EMIT;
                  s_ready_d = 1'b0;
                  m_valid_d = 1'b1;
                  m_data_d  = funnel_word;
                  m_last_d  = (LAST_IDX == '0);
               end else begin
                  wr_cnt_d = wr_cnt_q + 1'b1;
               end
            end
         end
         EMIT: begin
            if (m_hs) begin
               if (rd_cnt_q == LAST_IDX) begin
                  rd_cnt_d  = '0;
                  state_d   = LOAD;
                  s_ready_d = 1'b1;
                  m_valid_d = 1'b0;
                  m_last_d  = 1'b0;
               end else begin
                  rd_cnt_d = next_rd;
                  m_data_d = funnel_word;
                  m_last_d = (next_rd == LAST_IDX);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q   <= IDLE;
         wr_cnt_q  <= '0;
         rd_cnt_q  <= '0;
         shift_q   <= '0;
         s_ready_q <= 1'b0;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
         m_data_q  <= '0;
      end else begin
         state_q   <= state_d;
         wr_cnt_q  <= wr_cnt_d;
         rd_cnt_q  <= rd_cnt_d;
         shift_q   <= shift_d;
         s_ready_q <= s_ready_d;
         m_valid_q <= m_valid_d;
         m_last_q  <= m_last_d;
         m_data_q  <= m_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rstn && s_hs) begin
         buf_mem[wr_cnt_q] <= s_data;
      end
   end

   assign s_ready = s_ready_q;
   assign m_valid = m_valid_q;
   assign m_last  = m_last_q;
   assign m_data  = m_data_q;

endmodule

// File: tb/tb_hv_unpermute.sv
// Bench for hv_unpermute: an 8-word and a 1-word instance, each with a
// scoreboard filled from a full-vector rotate model as stimulus is driven.
module tb_hv_unpermute;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   logic        s_valid8, s_ready8, m_valid8, m_last8;
   logic [31:0] s_data8, m_data8;
   logic [7:0]  s_shift8;
   logic        s_valid1, s_ready1, m_valid1, m_last1;
   logic [31:0] s_data1, m_data1;
   logic [4:0]  s_shift1;
   logic        m_ready;

   int errors = 0;
   int checks = 0;
   logic [32:0] sb8[$];
   logic [32:0] sb1[$];
   bit rand_ready = 1'b0;

   hv_unpermute #(.N_WORDS(8)) u_dut8 (
      .clk(clk), .rstn(rstn),
      .s_valid(s_valid8), .s_ready(s_ready8), .s_data(s_data8), .s_shift(s_shift8),
      .m_valid(m_valid8), .m_ready(m_ready), .m_data(m_data8), .m_last(m_last8)
   );

   hv_unpermute #(.N_WORDS(1)) u_dut1 (
      .clk(clk), .rstn(rstn),
      .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data1), .s_shift(s_shift1),
      .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1), .m_last(m_last1)
   );

   function automatic logic [255:0] rotl256(input logic [255:0] v, input int s);
      if (s == 0) return v;
      return (v << s) | (v >> (256 - s));
   endfunction

   initial begin
      m_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Scoreboard and stability monitor for the 8-word instance.
   bit          hold8 = 1'b0;
   logic [31:0] hold_data8;
   logic        hold_last8;
   always @(negedge clk) begin
      logic [32:0] exp8;
      if (!rstn) begin
         hold8 = 1'b0;
      end else begin
         if (hold8) begin
            checks++;
            if (m_data8 !== hold_data8 || m_last8 !== hold_last8) begin
               errors++;
               $display("FAIL hold8 got=%h/%b want=%h/%b", m_data8, m_last8, hold_data8, hold_last8);
            end
         end
         if (m_valid8) begin
            checks++;
            if (s_ready8 !== 1'b0) begin
               errors++;
               $display("FAIL sready_emit8 got=%b want=0", s_ready8);
            end
         end
         if (m_valid8 && m_ready) begin
            checks++;
            if (sb8.size() == 0) begin
               errors++;
               $display("FAIL unexpected8 got=%h want=no output", m_data8);
            end else begin
               exp8 = sb8.pop_front();
               $display("txn8 data=%h last=%b", m_data8, m_last8);
               if ({m_last8, m_data8} !== exp8) begin
                  errors++;
                  $display("FAIL out8 got=%h/%b want=%h/%b", m_data8, m_last8, exp8[31:0], exp8[32]);
               end
            end
         end
         hold8 = m_valid8 && !m_ready;
         hold_data8 = m_data8;
         hold_last8 = m_last8;
      end
   end

   // Scoreboard for the 1-word instance.
   always @(negedge clk) begin
      logic [32:0] exp1;
      if (rstn && m_valid1 && m_ready) begin
         checks++;
         if (sb1.size() == 0) begin
            errors++;
            $display("FAIL unexpected1 got=%h want=no output", m_data1);
         end else begin
            exp1 = sb1.pop_front();
            $display("txn1 data=%h last=%b", m_data1, m_last1);
            if ({m_last1, m_data1} !== exp1) begin
               errors++;
               $display("FAIL out1 got=%h/%b want=%h/%b", m_data1, m_last1, exp1[31:0], exp1[32]);
            end
         end
      end
   end

   task automatic send8(input logic [31:0] w [8], input int s, input bit gaps);
      logic [255:0] v;
      logic [255:0] r;
      int cyc;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = w[i];
      r = rotl256(v, s);
      for (int j = 0; j < 8; j++) sb8.push_back({(j == 7), r[j*32 +: 32]});
      for (int i = 0; i < 8; i++) begin
         if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
               s_valid8 = 1'b0;
               @(posedge clk);
               #1;
            end
         end
         s_valid8 = 1'b1;
         s_data8  = w[i];
         s_shift8 = (i == 0) ? 8'(s) : 8'($urandom);
         cyc = 0;
         @(negedge clk);
         while (!s_ready8) begin
            cyc++;
            if (cyc > 500) begin
               checks++;
               errors++;
               $display("FAIL sready8_timeout got=0 want=1");
               s_valid8 = 1'b0;
               return;
            end
            @(negedge clk);
         end
         @(posedge clk);
         #1;
      end
      s_valid8 = 1'b0;
   endtask

   task automatic send1(input logic [31:0] x, input logic [31:0] din, input int s, input bit gaps);
      int cyc;
      sb1.push_back({1'b1, x});
      if (gaps) begin
         while ($urandom_range(0, 1) == 1) begin
            s_valid1 = 1'b0;
            @(posedge clk);
            #1;
         end
      end
      s_valid1 = 1'b1;
      s_data1  = din;
      s_shift1 = 5'(s);
      cyc = 0;
      @(negedge clk);
      while (!s_ready1) begin
         cyc++;
         if (cyc > 500) begin
            checks++;
            errors++;
            $display("FAIL sready1_timeout got=0 want=1");
            s_valid1 = 1'b0;
            return;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      s_valid1 = 1'b0;
   endtask

   task automatic wait_drain;
      int cyc = 0;
      while ((sb8.size() != 0 || m_valid8 || sb1.size() != 0 || m_valid1) && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (sb8.size() != 0 || sb1.size() != 0 || m_valid8 || m_valid1) begin
         errors++;
         $display("FAIL drain got=%0d/%0d pending want=0/0", sb8.size(), sb1.size());
         sb8.delete();
         sb1.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      s_valid8 = 1'b0; s_data8 = '0; s_shift8 = '0;
      s_valid1 = 1'b0; s_data1 = '0; s_shift1 = '0;
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({s_ready8, m_valid8, m_last8, m_data8} !== 35'd0) begin
         errors++;
         $display("FAIL reset8 got=%b%b%b/%h want=000/00000000", s_ready8, m_valid8, m_last8, m_data8);
      end
      checks++;
      if ({s_ready1, m_valid1, m_last1, m_data1} !== 35'd0) begin
         errors++;
         $display("FAIL reset1 got=%b%b%b/%h want=000/00000000", s_ready1, m_valid1, m_last1, m_data1);
      end
      rstn = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (s_ready8 !== 1'b1 || s_ready1 !== 1'b1) begin
         errors++;
         $display("FAIL sready_rise got=%b%b want=11", s_ready8, s_ready1);
      end
   endtask

   task automatic test_shift0;
      logic [31:0] w [8];
      for (int i = 0; i < 8; i++) w[i] = 32'hA5A50000 + 32'(i);
      send8(w, 0, 1'b0);
      checks++;
      if (m_valid8 !== 1'b1 || m_data8 !== 32'hA5A50000 || m_last8 !== 1'b0) begin
         errors++;
         $display("FAIL latency8 got=%b/%h/%b want=1/a5a50000/0", m_valid8, m_data8, m_last8);
      end
      wait_drain();
   endtask

   task automatic test_word_shift;
      logic [31:0] w [8];
      for (int i = 0; i < 8; i++) w[i] = 32'(i);
      send8(w, 32, 1'b0);
      wait_drain();
   endtask

   task automatic test_bit_shift;
      logic [31:0] w [8];
      for (int i = 0; i < 8; i++) w[i] = '0;
      w[0] = 32'hF0000001;
      send8(w, 4, 1'b0);
      w[0] = 32'h00000001;
      send8(w, 255, 1'b0);
      wait_drain();
   endtask

   task automatic test_single_word;
      logic [31:0] x;
      logic [63:0] t;
      int s;
      send1(32'h34567812, 32'h12345678, 8, 1'b0);
      wait_drain();
      rand_ready = 1'b1;
      for (int k = 0; k < 1000; k++) begin
         x = $urandom;
         s = $urandom_range(0, 31);
         t = {x, x} >> s;
         send1(x, t[31:0], s, (k % 4) == 0);
      end
      wait_drain();
      rand_ready = 1'b0;
   endtask

   task automatic test_back_to_back_random;
      logic [31:0] w [8];
      rand_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         for (int i = 0; i < 8; i++) w[i] = $urandom;
         send8(w, $urandom_range(0, 255), 1'b1);
      end
      wait_drain();
      rand_ready = 1'b0;
   endtask

   task automatic test_reset_mid_emit;
      logic [31:0] w [8];
      int cyc = 0;
      for (int i = 0; i < 8; i++) w[i] = $urandom;
      send8(w, 77, 1'b0);
      while (sb8.size() > 4 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (sb8.size() != 4) begin
         errors++;
         $display("FAIL mid_emit_timeout got=%0d pending want=4", sb8.size());
      end
      @(posedge clk);
      #1;
      rstn = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if ({s_ready8, m_valid8, m_last8, m_data8} !== 35'd0) begin
         errors++;
         $display("FAIL mid_reset8 got=%b%b%b/%h want=000/00000000", s_ready8, m_valid8, m_last8, m_data8);
      end
      sb8.delete();
      rstn = 1'b1;
      checks++;
      if (s_ready8 !== 1'b0) begin
         errors++;
         $display("FAIL sready_early got=%b want=0", s_ready8);
      end
      @(posedge clk);
      #1;
      checks++;
      if (s_ready8 !== 1'b1) begin
         errors++;
         $display("FAIL sready_after_reset got=%b want=1", s_ready8);
      end
      for (int i = 0; i < 8; i++) w[i] = $urandom;
      send8(w, 133, 1'b0);
      wait_drain();
   endtask

   initial begin
      test_reset();
      test_shift0();
      test_word_shift();
      test_bit_shift();
      test_single_word();
      test_back_to_back_random();
      test_reset_mid_emit();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/hv_unpermute.md
# hv_unpermute

Streaming inverse permutation unit for the HPU hypervector datapath. Accepts a hypervector of `N_WORDS` × 32 bits, delivered as a word stream, least-significant word first. Buffers the whole vector, then emits it rotated left by a per-vector shift amount. This undoes the HPU rotate-right permutation, and with `N_WORDS=1` it is the exact inverse of the 32-bit word rotate-right. Sits between the permute/bind stages and the associative-memory readback path.

## Interface
- `N_WORDS`, default 8: words per hypervector; must be a power of two, ≥1.
- `SHIFT_W`, default `$clog2(32*N_WORDS)` (min 5): shift width. Not to be overridden.
- Reset `rstn`, synchronous, active-low; clock `clk`.
- `clk`  in  1  clock.
- `rstn`  in  1  synchronous active-low reset.
- `s_valid`  in  1  input word valid.
- `s_ready`  out  1  block accepts input word.
- `s_data`  in  32  input word.
- `s_shift`  in  SHIFT_W  left-rotate amount (bits); sampled on the first word's handshake only.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accepts word.
- `m_data`  out  32  output word (registered).
- `m_last`  out  1  marks output word `N_WORDS-1`.

## Operation
- Vector bit `i` = word `i/32`, bit `i%32`. D = 32·N_WORDS.
- Output bit `i` = input bit `(i − s) mod D`, i.e. rotl(vec, s). Every `s` in range is legal; wrap is implicit in the power-of-two D.
- Decompose the shift: q = s[SHIFT_W-1:5] (word offset), r = s[4:0] (bit offset).
- Output word j = (in[(j−q) mod N] << r) | (in[(j−q−1) mod N] >> (32−r)). Indices wrap modulo N_WORDS.
- When r = 0, the second term is 0. Never shift by 32.
- States:
  - IDLE: reset only. Goes unconditionally to LOAD one cycle after `rstn`=1.
  - LOAD: `s_ready`=1. Each handshake writes buffer[wr_cnt] and increments wr_cnt. The handshake with wr_cnt=0 also latches `s_shift`. The handshake with wr_cnt=N_WORDS−1 goes to EMIT and clears wr_cnt.
  - EMIT: `s_ready`=0. `m_data` holds output word rd_cnt. On handshake, rd_cnt increments and the next word is loaded into `m_data`. The handshake on the last word goes to LOAD, clears rd_cnt, and drops `m_valid` and `m_last`.
- No overlap of load and emit. Throughput is one vector per ≥2·N_WORDS cycles.
- Input gaps (`s_valid`=0) and backpressure (`m_ready`=0) are allowed at any cycle.

## Timing
- Reset values:
  - `s_ready`=0, `m_valid`=0, `m_last`=0, `m_data`=0.
  - state=IDLE, counters=0, latched shift=0.
  - Buffer contents are don't-care.
- `s_ready` rises the 2nd cycle after `rstn` deasserts, and is registered.
- Latency: `m_valid`=1 and output word 0 in `m_data` the cycle after the last input handshake.
- While `m_valid`=1 and `m_ready`=0, `m_data` and `m_last` are held stable.
- One output word per cycle under continuous `m_ready`.
- `s_ready` rises the cycle after the last output handshake.
- `m_last`=1 exactly with word N_WORDS−1.
- Reset mid-LOAD or mid-EMIT: the next cycle is IDLE, the partial vector is discarded, and all outputs return to reset values.
- `s_shift` changes after the first word has no effect on the current vector.

## Structure
- Shared package `hpu_pkg`:
  - `HV_WORD_W=32`.
  - state enum `unperm_state_t` {IDLE, LOAD, EMIT}.
  - function `rotl_word_sel` computing one output word from two buffer words and r.
- One sub-module: `hv_funnel_word`, combinational. Inputs: hi word, lo word, r[4:0]. Output: funnelled 32-bit word, with the r=0 case handled.
- Top holds the buffer array, counters, FSM and output register.

## Test plan
- N=8, s=0, in word i = 0xA5A50000+i → out word i = 0xA5A50000+i; `m_last` on word 7 only; `m_valid` the cycle after the 8th input.
- N=8, s=32, in word i = i → out0 = 7, out j = j−1 (word wrap).
- N=8, s=4:
  - in0 = 0xF0000001, others 0 → out0 = 0x00000010, out1 = 0x0000000F, others 0.
  - s=255, in0 = 1, others 0 → out7 = 0x80000000 (full-vector wrap).
- N=1, s=8, in = 0x12345678 → out = 0x34567812. Random rotate-right(x, s) then this block returns x for 1000 random (x, s).
- Random `s_valid` gaps and `m_ready` toggling at 50% → results match the model; `m_data` and `m_last` never change while `m_valid` && !`m_ready`; `s_ready` is 0 throughout EMIT.
- `rstn`=0 for 1 cycle after output word 3 of 8 → `m_valid`=0 the next cycle, `s_ready`=1 two cycles after release, and the next vector is processed correctly.
